intsched_core: RTL

Interrupt scheduling core of the InterruptScheduler IP. It sits directly downstream of the AXI4-Lite register bank (S00_AXI) and consumes its four registers: enable mask, clear mask, holdoff count and status. It captures rising edges on up to NUM_SRC interrupt sources and selects one pending, enabled source at a time using round-robin order. It presents that source's ID on a valid/ready handshake and enforces a programmable minimum spacing between consecutive grants.

---
 rtl/intsched_core.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/intsched_core.sv
// intsched_core: interrupt scheduling core.
// Captures rising edges on NUM_SRC interrupt sources and keeps one pending bit
// per source. A round-robin arbiter picks one pending, enabled source at a time.
// The pick is offered on a valid/ready handshake, and a programmable holdoff is
// enforced between consecutive grants.
// Optional feature: define INTSCHED_SYNC_EN to put a 2-flop synchroniser in
// front of the edge detector, so that the sources may be asynchronous.
module intsched_core #(
  parameter  int NUM_SRC   = 8,
  parameter  int HOLDOFF_W = 16,
  localparam int ID_W      = $clog2(NUM_SRC)
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic [NUM_SRC-1:0]   enable_mask,
  input  logic                 clear_pulse,
  input  logic [NUM_SRC-1:0]   clear_mask,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic                 irq_valid,
  output logic [ID_W-1:0]      irq_id,
  input  logic                 irq_ready,
  output logic                 irq_out,
  output logic [NUM_SRC-1:0]   pending,
  output logic [NUM_SRC-1:0]   overflow
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  logic [1:0]           state;
  logic [HOLDOFF_W-1:0] cnt;
  logic [ID_W-1:0]      rr_ptr;
  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   src_q_d;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   clr_vec;
  logic [NUM_SRC-1:0]   hs_vec;
  logic [NUM_SRC-1:0]   pend_nxt;
  logic [NUM_SRC-1:0]   ovf_nxt;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_found;
  logic                 hs;

`ifdef INTSCHED_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  // Two synchroniser stages, followed by the sample register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync1 <= '0;
      sync2 <= '0;
      src_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop in the chain sample the
      // old value of its predecessor. This is what makes it a shift chain.
      sync1 <= irq_src;
      sync2 <= sync1;
      src_q <= sync2;
    end
  end
`else
  // Sources are already synchronous to ACLK. They are registered once.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      src_q <= '0;
    end else begin
      // NOTE: non-blocking assignments give every register the pre-edge value
      // of its inputs, independent of the order of the statements.
      src_q <= irq_src;
    end
  end
`endif

  // Delayed copy of the sample for edge detection. It resets low, so a source
  // that is high at reset release is seen as one rise.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) src_q_d <= '0;
    else          src_q_d <= src_q;
  end

  assign rise      = src_q & ~src_q_d;
  assign req       = pending & enable_mask;
  assign hs        = (state == ST_ISSUE) && irq_ready;
  assign irq_valid = (state == ST_ISSUE);

  // Next pending/overflow. A rise beats a clear or a handshake in the same
  // cycle, and that collision does not count as an overflow.
  always_comb begin
    // NOTE: each variable gets a default before any conditional logic. Without
    // it, a path that skips an assignment would infer a latch.
    clr_vec  = clear_pulse ? clear_mask : '0;
    hs_vec   = '0;
    if (hs) hs_vec = {{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id;
    pend_nxt = rise | (pending & ~clr_vec & ~hs_vec);
    ovf_nxt  = (overflow & ~clr_vec) | (rise & pending & ~clr_vec & ~hs_vec);
  end

  // Round-robin search over req, starting at rr_ptr and wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!arb_found && req[idx]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(idx);
      end
    end
  end

  // Pending, overflow and the registered CPU interrupt level.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pending  <= '0;
      overflow <= '0;
      irq_out  <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      overflow <= ovf_nxt;
      irq_out  <= |req;
    end
  end

  // Grant FSM: IDLE picks a source, ISSUE holds the offer until it is accepted,
  // and HOLDOFF counts down the minimum spacing between grants.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state  <= ST_IDLE;
      irq_id <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            irq_id <= arb_id;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (irq_ready) begin
            rr_ptr <= (irq_id == ID_W'(NUM_SRC - 1)) ? '0 : irq_id + ID_W'(1);
            if (holdoff == '0) begin
              state <= ST_IDLE;
            end else begin
              cnt   <= holdoff;
              state <= ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          cnt <= cnt - HOLDOFF_W'(1);
          if (cnt <= HOLDOFF_W'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
